// File: rtl/sdram_wr_buf.sv
// sdram_wr_buf: write-side staging FIFO (first-word-fall-through) in front of
// the SDRAM write engine. Raises a one-cycle wr_trig once a full burst is
// buffered, then waits for the engine's flag_wr_end before it can trigger again.
module sdram_wr_buf #(
  parameter int DW    = 16,
  parameter int AW    = 4,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic          din_rdy,
  output logic          wr_trig,
  input  logic          wr_data_req,
  output logic [DW-1:0] wr_data,
  input  logic          flag_wr_end,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          udf
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LVL  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] BURST_LVL = (AW+1)'(BURST);

  // One-hot trigger states; each state owns exactly one bit.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    TRIG = 3'b010,
    BUSY = 3'b100
  } state_t;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  state_t        state;
  state_t        state_next;

  // Occupancy alone decides full/empty; pointers wrap freely so they cannot.
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign din_rdy = ~full;

  // A pop never frees room for a same-cycle push when full, and a push never
  // feeds a same-cycle pop when empty: both decisions use the current level.
  assign push = din_vld & ~full;
  assign pop  = wr_data_req & ~empty;

  // Head of FIFO is presented combinationally so the engine samples it in the
  // same cycle it raises wr_data_req.
  assign wr_data = mem[rd_ptr];

  // Storage array; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky error flags: any push into a full FIFO or pop from an empty one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (din_vld && full) begin
        ovf <= 1'b1;
      end
      if (wr_data_req && empty) begin
        udf <= 1'b1;
      end
    end
  end

  // Trigger state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Trigger next-state and pulse decode; decisions use the registered level.
  always_comb begin
    state_next = state;
    wr_trig    = 1'b0;
    unique case (state)
      IDLE: begin
        if (level >= BURST_LVL) begin
          state_next = TRIG;
        end
      end
      TRIG: begin
        wr_trig    = 1'b1;
        state_next = BUSY;
      end
      BUSY: begin
        if (flag_wr_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_wr_buf.sv
// tb_sdram_wr_buf: directed scenarios plus randomized traffic, checked by a
// negedge monitor against a queue-based reference of the write buffer.
module tb_sdram_wr_buf;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int BURST = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_vld = 1'b0;
  logic          din_rdy;
  logic          wr_trig;
  logic          wr_data_req = 1'b0;
  logic [DW-1:0] wr_data;
  logic          flag_wr_end = 1'b0;
  logic [AW:0]   level;
  logic          ovf;
  logic          udf;

  int checks = 0;
  int errors = 0;
  int trig_cnt = 0;
  int pop_cnt = 0;

  // Reference state: expected FIFO contents and burst bookkeeping.
  logic [DW-1:0] exp_q[$];
  logic          ovf_m = 1'b0;
  logic          udf_m = 1'b0;
  logic          trig_m = 1'b0;
  logic          outst_m = 1'b0;
  int            sz;

  sdram_wr_buf #(.DW(DW), .AW(AW), .BURST(BURST)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_vld     (din_vld),
    .din_rdy     (din_rdy),
    .wr_trig     (wr_trig),
    .wr_data_req (wr_data_req),
    .wr_data     (wr_data),
    .flag_wr_end (flag_wr_end),
    .level       (level),
    .ovf         (ovf),
    .udf         (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs just after an edge, return just after the next.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic e);
    din_vld     = v;
    din         = d;
    wr_data_req = r;
    flag_wr_end = e;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && level != '0; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_level", 32'(level), 32'd0);
  endtask

  task automatic end_burst();
    cyc(1'b0, '0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_din_rdy"}, 32'(din_rdy), 32'd1);
    chk({tag, "_wr_trig"}, 32'(wr_trig), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_udf"}, 32'(udf), 32'd0);
  endtask

  // Monitor: compare DUT outputs with the reference, then advance the
  // reference by the transactions that the coming edge will accept.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      ovf_m   = 1'b0;
      udf_m   = 1'b0;
      trig_m  = 1'b0;
      outst_m = 1'b0;
    end else begin
      sz = exp_q.size();
      chk("level", 32'(level), 32'(sz));
      chk("din_rdy", 32'(din_rdy), 32'(sz < DEPTH));
      chk("ovf", 32'(ovf), 32'(ovf_m));
      chk("udf", 32'(udf), 32'(udf_m));
      chk("wr_trig", 32'(wr_trig), 32'(trig_m));
      if (wr_trig) trig_cnt++;
      if (wr_data_req && sz > 0) begin
        pop_cnt++;
        $display("pop %0d: wr_data=%h exp=%h", pop_cnt, wr_data, exp_q[0]);
        chk("wr_data", 32'(wr_data), 32'(exp_q[0]));
      end
      if (din_vld && sz == DEPTH) ovf_m = 1'b1;
      if (wr_data_req && sz == 0) udf_m = 1'b1;
      // A burst is outstanding from its trigger cycle until an end flag seen
      // after that cycle; a new trigger needs a free engine and a full burst.
      begin
        logic trig_now;
        trig_now = trig_m;
        trig_m   = !outst_m && !trig_now && (sz >= BURST);
        if (trig_now) outst_m = 1'b1;
        else if (outst_m && flag_wr_end) outst_m = 1'b0;
      end
      if (wr_data_req && sz > 0) void'(exp_q.pop_front());
      if (din_vld && sz < DEPTH) exp_q.push_back(din);
    end
  end

  initial begin
    int t0;
    logic [DW-1:0] w;
    // Power-on reset.
    #1 rst = 1'b1;
    #1 chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, '0, 1'b0, 1'b0);

    // Single burst of four words.
    t0 = trig_cnt;
    cyc(1'b1, 16'h1111, 1'b0, 1'b0);
    cyc(1'b1, 16'h2222, 1'b0, 1'b0);
    cyc(1'b1, 16'h3333, 1'b0, 1'b0);
    cyc(1'b1, 16'h4444, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("single_level", 32'(level), 32'd0);
    end_burst();
    chk("single_trig_count", 32'(trig_cnt - t0), 32'd1);

    // Fill past capacity with no pops, then read everything back.
    for (int i = 1; i <= DEPTH + 1; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    chk("full_level", 32'(level), 32'(DEPTH));
    chk("full_din_rdy", 32'(din_rdy), 32'd0);
    chk("full_ovf", 32'(ovf), 32'd1);
    repeat (DEPTH) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("full_drained", 32'(level), 32'd0);
    end_burst();

    // Sustained push+pop at level 5 across pointer wrap.
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, DW'($urandom), 1'b1, 1'b0);
    chk("stream_level", 32'(level), 32'd5);
    drain();
    end_burst();

    // Underflow, then a clean push/pop.
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("udf_set", 32'(udf), 32'd1);
    chk("udf_level", 32'(level), 32'd0);
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("udf_push_level", 32'(level), 32'd1);
    chk("udf_push_data", 32'(wr_data), 32'h0000BEEF);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Re-arm gating: spurious end in idle, two bursts buffered.
    cyc(1'b0, '0, 1'b0, 1'b1);
    t0 = trig_cnt;
    for (int i = 0; i < 8; i++) cyc(1'b1, DW'($urandom), 1'b0, 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
    chk("rearm_one_trig", 32'(trig_cnt - t0), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
    chk("rearm_two_trig", 32'(trig_cnt - t0), 32'd2);
    drain();
    end_burst();

    // Randomized traffic with shifting push/pop bias.
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 400; i++) begin
        logic v;
        logic r;
        v = ($urandom_range(99) < ((seg % 2 == 0) ? 75 : 30));
        r = ($urandom_range(99) < ((seg % 2 == 0) ? 30 : 75));
        w = DW'($urandom);
        cyc(v, w, r, ($urandom_range(15) == 0));
      end
    end
    drain();
    end_burst();

    // Reset in the middle of a stream with seven words buffered.
    for (int i = 0; i < 7; i++) cyc(1'b1, DW'($urandom), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd7);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("mid_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_wr_buf.md
# sdram_wr_buf

Write-side staging buffer placed directly upstream of the SDRAM write engine. It accepts a user data stream into a first-word-fall-through FIFO. When at least one full burst is buffered, it raises a single-cycle write trigger. It then supplies one word per data request while the write engine runs the burst, and re-arms only after the engine reports burst end.

## Interface
- DW, 16, data width; matches the SDRAM DQ bus.
- AW, 4, FIFO address width; depth is 2^AW = 16 words.
- BURST, 4, words per write burst; legal range 1..2^AW.

- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous and active-high. Asserting it clears all state immediately; release is synchronous to clk.
- din  input  DW  user write data.
- din_vld  input  1  user data valid; push when din_vld & din_rdy.
- din_rdy  output  1  FIFO not full. Combinational from level.
- wr_trig  output  1  one-cycle pulse to write engine; a burst is available.
- wr_data_req  input  1  write engine pops one word this cycle.
- wr_data  output  DW  head-of-FIFO word, valid whenever level > 0 (FWFT).
- flag_wr_end  input  1  write engine burst complete, one-cycle pulse.
- level  output  AW+1  current occupancy, 0..2^AW.
- ovf  output  1  sticky: push attempted while full.
- udf  output  1  sticky: pop requested while empty.

## Operation
- Storage: 2^AW x DW register array. Pointers wr_ptr and rd_ptr are AW bits and wrap modulo 2^AW. level is a separate AW+1-bit counter.
- Push: din_vld & ~full writes mem[wr_ptr] and increments wr_ptr.
- Pop: wr_data_req & ~empty increments rd_ptr. wr_data = mem[rd_ptr], read combinationally.
- Level update:
  - push only: level + 1
  - pop only: level - 1
  - push and pop in the same cycle: unchanged, both pointers advance
  - push and pop in the same cycle when empty: the push is accepted, the pop is rejected, udf is set, level = 1
  - push and pop in the same cycle when full: the pop is accepted, the push is rejected (din_rdy = 0 that cycle), ovf is set, level = 2^AW - 1
- full = (level == 2^AW); empty = (level == 0).
- Rejected push: data is dropped, wr_ptr and level are unchanged, ovf is set until rst.
- Rejected pop: rd_ptr and level are unchanged, udf is set until rst. wr_data shows mem[rd_ptr] (stale; do not care).
- Trigger FSM, one-hot, 3 states:
  - IDLE: if level >= BURST, go to TRIG.
  - TRIG: wr_trig = 1 for exactly this cycle; go to BUSY unconditionally.
  - BUSY: wait for flag_wr_end, then go to IDLE. Pops are accepted whenever requested.
- flag_wr_end in IDLE or TRIG is ignored. No state change; no error flag.
- Exactly one wr_trig per flag_wr_end. At most one burst is outstanding.
- FSM decisions use the registered level value (pre-update).

## Timing
- Reset values: state = IDLE, wr_trig = 0, level = 0, wr_ptr = rd_ptr = 0, ovf = udf = 0, din_rdy = 1. wr_data is undefined (memory is not cleared).
- Data latency: a word pushed at edge N is visible on wr_data after edge N (same cycle as level = 1).
- Trigger latency:
  - level reaches BURST at edge N, so the FSM enters TRIG at edge N+1 and wr_trig is high in cycle N+1..N+2.
  - IDLE re-entry with level >= BURST already true triggers on the next edge, giving back-to-back bursts with a 2-cycle minimum gap after flag_wr_end.
- Pop timing: the engine samples wr_data in the same cycle it asserts wr_data_req. The next word appears after that edge.
- Throughput: 1 push and 1 pop per cycle sustained.
- Reset mid-burst: asserting rst drops all buffered data and returns the FSM to IDLE asynchronously. The write engine must be reset by the same rst.

## Test plan
- Reset: assert rst mid-stream with level = 7 -> level = 0, din_rdy = 1, wr_trig = 0, ovf = udf = 0 immediately, before the next clk edge.
- Single burst: push 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles -> wr_trig pulses once, 2 cycles after the 4th push edge. Then 4 pops return the same 4 words in order, level = 0. flag_wr_end returns the FSM to IDLE with no second trigger.
- Full/overflow: push 17 words with no pops -> din_rdy = 0 after the 16th, the 17th word is dropped, ovf = 1, level = 16. Popping 16 returns words 1..16 and wrap-around is correct.
- Simultaneous push and pop at level 5 for 20 cycles -> level stays 5, data order preserved across pointer wrap.
- Underflow: wr_data_req with level = 0 -> udf = 1, level stays 0, rd_ptr is unchanged. A subsequent push is readable correctly.
- Re-arm gating: 8 words buffered -> exactly one wr_trig; no second trigger until flag_wr_end. After flag_wr_end the second wr_trig follows 2 cycles later. A spurious flag_wr_end in IDLE has no effect.
